tick_watchdog: RTL and testbench
================================

TICK_WATCHDOG -- requirements
Module: tick_watchdog

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the timeout and count values, in ticks.
REQ-002 SHALL have parameter ECNT_W, default 4: width of the saturating expiry counter.
REQ-003 SHALL have input iClk, 1 bit: system clock.
REQ-004 SHALL have input iRst_n, 1 bit: reset, asynchronous, active-low. Clock is iClk.
REQ-005 SHALL have input iTick, 1 bit: periodic enable pulse, one iClk wide, from the system tick divider.
REQ-006 SHALL have input iStart, 1 bit: arm the watchdog with iTimeout.
REQ-007 SHALL have input iKick, 1 bit: reload the count while running.
REQ-008 SHALL have input iStop, 1 bit: disarm and return to idle.
REQ-009 SHALL have input iTimeout, CNT_W bits: timeout in ticks, sampled on start or kick.
REQ-010 SHALL have output oRunning, 1 bit: high while in RUN.
REQ-011 SHALL have output oExpired, 1 bit: high while in EXPIRED.
REQ-012 SHALL have output oExpPulse, 1 bit: one-iClk pulse on entry to EXPIRED.
REQ-013 SHALL have output oCount, CNT_W bits: remaining ticks.
REQ-014 SHALL have output oExpCnt, ECNT_W bits: number of expiries, saturating.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and EXPIRED.
REQ-016 SHALL register all outputs; each output SHALL reflect an input event on the iClk edge following that event.
REQ-017 SHALL apply iStop with highest priority in every state: next state IDLE, oCount=0, no pulse.
REQ-018 IDLE: iStart with iTimeout>0 SHALL go to RUN with oCount=iTimeout. iStart with iTimeout=0 SHALL go directly to EXPIRED and pulse oExpPulse.
REQ-019 RUN: on iTick, oCount SHALL decrement by 1. When oCount=1 and iTick=1, next state SHALL be EXPIRED with oCount=0 and oExpPulse=1 for exactly one cycle.
REQ-020 RUN: iKick SHALL reload oCount=iTimeout and take priority over a simultaneous iTick. A kick with iTimeout=0 SHALL expire as in REQ-018.
REQ-021 RUN: iStart SHALL behave as iKick.
REQ-022 EXPIRED: state SHALL be held and oCount SHALL stay 0. iKick and iTick SHALL be ignored. iStart SHALL re-arm per REQ-018.
REQ-023 iTick in IDLE or EXPIRED SHALL have no effect.
REQ-024 oExpCnt SHALL increment on every oExpPulse and saturate at 2^ECNT_W-1. Only reset SHALL clear it.
REQ-025 Timeout resolution: expiry SHALL occur between (N-1) and N tick periods after arming, because tick phase is unsynchronised. This is documented behaviour, not a defect.
REQ-026 oCount SHALL never underflow. No decrement SHALL occur at 0.
REQ-027 iTick asserted on consecutive cycles SHALL decrement once per cycle. No edge detection is required.

Reset
REQ-028 While iRst_n=0: state=IDLE, oCount=0, oRunning=0, oExpired=0, oExpPulse=0, oExpCnt=0.
REQ-029 Reset asserted mid-RUN or mid-EXPIRED SHALL abort immediately and asynchronously, with no oExpPulse.
REQ-030 After release, the first active edge SHALL evaluate inputs normally.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding (2 bits: IDLE=0, RUN=1, EXPIRED=2) and the default CNT_W/ECNT_W constants.
REQ-032 The block SHALL be a single module with no sub-module. The tick source SHALL be instantiated externally at the integration level.
REQ-033 Target size: 120-250 RTL lines.

Verification
REQ-034 Reset, then iTimeout=3 and iStart; 3 iTicks spaced 10 cycles apart -> oCount 3,2,1,0; oExpPulse one cycle after the 3rd tick; oExpCnt=1.
REQ-035 Running with oCount=1, iKick and iTick in the same cycle with iTimeout=5 -> oCount=5, no expiry.
REQ-036 iStart with iTimeout=0 -> next cycle state EXPIRED, oExpPulse=1 for one cycle, oRunning=0.
REQ-037 Running with oCount=2, iStop and iTick together -> IDLE, oCount=0, no pulse. Subsequent ticks -> no change.
REQ-038 17 expiries with ECNT_W=4 -> oExpCnt=15 (saturated). iRst_n pulsed low mid-RUN -> all outputs 0 immediately.
REQ-039 In EXPIRED, iKick and iTick -> no change. iStart with iTimeout=2 -> RUN, oCount=2, oExpired=0.

Source files
------------

// File: rtl/tick_watchdog_pkg.sv
// tick_watchdog_pkg: shared FSM state encoding and default widths for tick_watchdog.
package tick_watchdog_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } wdState_t;
  localparam int DEF_CNT_W  = 8;
  localparam int DEF_ECNT_W = 4;
endpackage

// File: rtl/tick_watchdog.sv
// tick_watchdog: tick-driven watchdog with kick/stop control and a saturating expiry counter.
//   iClk, iRst_n      clock, asynchronous active-low reset
//   iTick             one-cycle enable pulse from the external tick divider
//   iStart/iKick/iStop arm, reload while running, disarm (stop wins)
//   iTimeout          timeout in ticks, sampled on start or kick
//   oRunning/oExpired registered state flags
//   oExpPulse         one-cycle pulse on entry to EXPIRED
//   oCount            remaining ticks
//   oExpCnt           saturating number of expiries, cleared only by reset
module tick_watchdog
  import tick_watchdog_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int ECNT_W = DEF_ECNT_W
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iTick,
  input  logic              iStart,
  input  logic              iKick,
  input  logic              iStop,
  input  logic [CNT_W-1:0]  iTimeout,
  output logic              oRunning,
  output logic              oExpired,
  output logic              oExpPulse,
  output logic [CNT_W-1:0]  oCount,
  output logic [ECNT_W-1:0] oExpCnt
);
  wdState_t         state, nextState;
  logic [CNT_W-1:0] nextCount;
  logic             arm, zeroTimeout, lastTick, expNow;
  // A kick only means something while running; start re-arms from any state.
  always_comb begin
    arm         = iStart | (state == RUN & iKick);
    zeroTimeout = iTimeout == '0;
    lastTick    = state == RUN & iTick & oCount == CNT_W'(1);
    expNow      = !iStop & (arm ? zeroTimeout : lastTick);
    nextState   = iStop ? IDLE
                : arm ? (zeroTimeout ? EXPIRED : RUN)
                : lastTick ? EXPIRED
                : state;
    nextCount   = iStop ? '0
                : arm ? iTimeout
                : (state == RUN & iTick & oCount != '0) ? oCount - 1'b1
                : oCount;
  end
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state     <= IDLE;
      oCount    <= '0;
      oRunning  <= 1'b0;
      oExpired  <= 1'b0;
      oExpPulse <= 1'b0;
      oExpCnt   <= '0;
    end else begin
      state     <= nextState;
      oCount    <= nextCount;
      oRunning  <= nextState == RUN;
      oExpired  <= nextState == EXPIRED;
      oExpPulse <= expNow;
      oExpCnt   <= (expNow && !(&oExpCnt)) ? oExpCnt + 1'b1 : oExpCnt;
    end
  end
endmodule

// File: tb/tb_tick_watchdog.sv
// tb_tick_watchdog: scoreboard bench with a behavioural watchdog model and random stimulus.
module tb_tick_watchdog;
  localparam int CW = 8;
  localparam int EW = 4;
  localparam int EMAX = (1 << EW) - 1;

  typedef struct {
    logic        running;
    logic        expired;
    logic        pulse;
    int unsigned count;
    int unsigned expCnt;
  } exp_t;

  logic          iClk = 1'b0;
  logic          iRst_n = 1'b0;
  logic          iTick = 1'b0;
  logic          iStart = 1'b0;
  logic          iKick = 1'b0;
  logic          iStop = 1'b0;
  logic [CW-1:0] iTimeout = '0;
  logic          oRunning, oExpired, oExpPulse;
  logic [CW-1:0] oCount;
  logic [EW-1:0] oExpCnt;

  int total = 0;
  int bad = 0;
  exp_t sb[$];

  // reference model: mode 0 idle, 1 running, 2 expired
  int mMode = 0;
  int mRem = 0;
  int mExp = 0;

  tick_watchdog #(.CNT_W(CW), .ECNT_W(EW)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iTick(iTick), .iStart(iStart), .iKick(iKick),
    .iStop(iStop), .iTimeout(iTimeout), .oRunning(oRunning), .oExpired(oExpired),
    .oExpPulse(oExpPulse), .oCount(oCount), .oExpCnt(oExpCnt)
  );

  always #5 iClk = ~iClk;

  function automatic void check(string name, int unsigned act, int unsigned req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endfunction

  always @(posedge iClk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("running", oRunning, e.running);
      check("expired", oExpired, e.expired);
      check("pulse", oExpPulse, e.pulse);
      check("count", oCount, e.count);
      check("expcnt", oExpCnt, e.expCnt);
    end
  end

  task automatic step(input bit st, input bit kk, input bit sp, input bit tk, input int to);
    exp_t e;
    bit pulse;
    @(negedge iClk);
    iStart = st; iKick = kk; iStop = sp; iTick = tk; iTimeout = CW'(to);
    pulse = 0;
    if (sp) begin
      mMode = 0; mRem = 0;
    end else if (st || (kk && mMode == 1)) begin
      if (to == 0) begin mMode = 2; mRem = 0; pulse = 1; end
      else begin mMode = 1; mRem = to; end
    end else if (mMode == 1 && tk) begin
      mRem = mRem - 1;
      if (mRem == 0) begin mMode = 2; pulse = 1; end
    end
    if (pulse && mExp < EMAX) mExp++;
    e.running = (mMode == 1);
    e.expired = (mMode == 2);
    e.pulse = pulse;
    e.count = mRem;
    e.expCnt = mExp;
    sb.push_back(e);
    @(posedge iClk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic asyncReset();
    @(posedge iClk);
    #3;
    iStart = 0; iKick = 0; iStop = 0; iTick = 0;
    iRst_n = 1'b0;
    #1;
    check("reset_outputs", {oRunning, oExpired, oExpPulse, oCount, oExpCnt}, 0);
    mMode = 0; mRem = 0; mExp = 0;
    @(negedge iClk);
    @(negedge iClk);
    iRst_n = 1'b1;
  endtask

  initial begin
    #2;
    check("reset_outputs", {oRunning, oExpired, oExpPulse, oCount, oExpCnt}, 0);
    @(negedge iClk);
    @(negedge iClk);
    iRst_n = 1'b1;
    // three-tick timeout runs to expiry
    step(1, 0, 0, 0, 3);
    for (int t = 0; t < 3; t++) begin
      idle(9);
      step(0, 0, 0, 1, 0);
    end
    idle(3);
    // kick with simultaneous tick at count 1 reloads
    step(1, 0, 0, 0, 2);
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 1, 5);
    idle(2);
    // zero timeout expires immediately
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    idle(2);
    // stop with tick at count 2, then ticks do nothing
    step(1, 0, 0, 0, 2);
    step(0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    // expired ignores kick and tick, start re-arms
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 7);
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 2);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    // saturation of the expiry counter
    for (int i = 0; i < 17; i++) step(1, 0, 0, 0, 0);
    idle(1);
    // async reset in the middle of a run
    step(1, 0, 0, 0, 9);
    step(0, 0, 0, 1, 0);
    asyncReset();
    idle(2);
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 5, $urandom_range(0, 99) < 8,
           $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 35,
           $urandom_range(0, 6));
      if (i == 1500) asyncReset();
    end
    idle(2);
    @(negedge iClk);
    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
